// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA controller AXI4-Lite control block:
// register offsets, control bit positions, response codes and FSM states.
package dmac_pkg;

   localparam logic [5:0] ADDR_USER_CTRL     = 6'h10;
   localparam logic [5:0] ADDR_BYTE_LEN_DATA = 6'h14;
   localparam logic [5:0] ADDR_SRC_DATA      = 6'h18;
   localparam logic [5:0] ADDR_DST_DATA      = 6'h1C;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_DONE_BIT  = 1;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wstate_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rstate_t;

   // Byte-lane merge of new write data over an existing register value.
   function automatic logic [31:0] apply_strb(
      input logic [31:0] old,
      input logic [31:0] data,
      input logic [3:0]  strb
   );
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dmac_ctrl_slave.sv
// AXI4-Lite control responder for the DMA controller: holds SRC/DST/LEN,
// issues the start pulse to the engine and reports busy/done status.
module dmac_ctrl_slave #(
   parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 12,
   parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32
) (
   input  logic                                  ap_clk,
   input  logic                                  ap_rst,
   input  logic                                  s_axi_control_awvalid,
   output logic                                  s_axi_control_awready,
   input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0] s_axi_control_awaddr,
   input  logic                                  s_axi_control_wvalid,
   output logic                                  s_axi_control_wready,
   input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0] s_axi_control_wdata,
   input  logic [3:0]                            s_axi_control_wstrb,
   output logic                                  s_axi_control_bvalid,
   input  logic                                  s_axi_control_bready,
   output logic [1:0]                            s_axi_control_bresp,
   input  logic                                  s_axi_control_arvalid,
   output logic                                  s_axi_control_arready,
   input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0] s_axi_control_araddr,
   output logic                                  s_axi_control_rvalid,
   input  logic                                  s_axi_control_rready,
   output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0] s_axi_control_rdata,
   output logic [1:0]                            s_axi_control_rresp,
   output logic                                  start_o,
   output logic [31:0]                           src_addr_o,
   output logic [31:0]                           dst_addr_o,
   output logic [31:0]                           byte_len_o,
   input  logic                                  busy_i,
   input  logic                                  done_i
);

   import dmac_pkg::*;

   localparam int AW = C_S_AXI_CONTROL_ADDR_WIDTH;

   localparam logic [3:0] OFF_CTRL = ADDR_USER_CTRL[5:2];
   localparam logic [3:0] OFF_LEN  = ADDR_BYTE_LEN_DATA[5:2];
   localparam logic [3:0] OFF_SRC  = ADDR_SRC_DATA[5:2];
   localparam logic [3:0] OFF_DST  = ADDR_DST_DATA[5:2];

   wstate_t     wstate;
   rstate_t     rstate;
   logic        aw_full;
   logic        w_full;
   logic [3:0]  aw_off;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        done_sticky;
   logic [31:0] rd_mux;
   logic        unused_ok;

   // Only address bits [5:2] select a register.
   assign unused_ok = ^{s_axi_control_awaddr[AW-1:6],
                        s_axi_control_awaddr[1:0],
                        s_axi_control_araddr[AW-1:6],
                        s_axi_control_araddr[1:0]};

   assign s_axi_control_bresp = RESP_OKAY;
   assign s_axi_control_rresp = RESP_OKAY;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         wstate                <= W_IDLE;
         s_axi_control_awready <= 1'b0;
         s_axi_control_wready  <= 1'b0;
         s_axi_control_bvalid  <= 1'b0;
         aw_full               <= 1'b0;
         w_full                <= 1'b0;
         aw_off                <= '0;
         w_data                <= '0;
         w_strb                <= '0;
         src_addr_o            <= '0;
         dst_addr_o            <= '0;
         byte_len_o            <= '0;
         start_o               <= 1'b0;
         done_sticky           <= 1'b0;
      end else begin
         start_o <= 1'b0;
         // An accepted start below overrides a same-cycle done.
         if (done_i) done_sticky <= 1'b1;
         unique case (wstate)
            W_IDLE: begin
               if (s_axi_control_awready && s_axi_control_awvalid) begin
                  aw_off                <= s_axi_control_awaddr[5:2];
                  aw_full               <= 1'b1;
                  s_axi_control_awready <= 1'b0;
               end else if (!aw_full) begin
                  s_axi_control_awready <= 1'b1;
               end
               if (s_axi_control_wready && s_axi_control_wvalid) begin
                  w_data               <= s_axi_control_wdata;
                  w_strb               <= s_axi_control_wstrb;
                  w_full               <= 1'b1;
                  s_axi_control_wready <= 1'b0;
               end else if (!w_full) begin
                  s_axi_control_wready <= 1'b1;
               end
               if (aw_full && w_full) begin
                  wstate               <= W_RESP;
                  s_axi_control_bvalid <= 1'b1;
                  case (aw_off)
                     OFF_LEN: byte_len_o <= apply_strb(byte_len_o, w_data, w_strb);
                     OFF_SRC: src_addr_o <= apply_strb(src_addr_o, w_data, w_strb);
                     OFF_DST: dst_addr_o <= apply_strb(dst_addr_o, w_data, w_strb);
                     OFF_CTRL: begin
                        if (w_strb[0] && w_data[CTRL_START_BIT] && !busy_i) begin
                           start_o     <= 1'b1;
                           done_sticky <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            W_RESP: begin
               if (s_axi_control_bready) begin
                  wstate                <= W_IDLE;
                  s_axi_control_bvalid  <= 1'b0;
                  aw_full               <= 1'b0;
                  w_full                <= 1'b0;
                  s_axi_control_awready <= 1'b1;
                  s_axi_control_wready  <= 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (s_axi_control_araddr[5:2])
         OFF_CTRL: begin
            rd_mux[CTRL_START_BIT] = busy_i;
            rd_mux[CTRL_DONE_BIT]  = done_sticky;
         end
         OFF_LEN: rd_mux = byte_len_o;
         OFF_SRC: rd_mux = src_addr_o;
         OFF_DST: rd_mux = dst_addr_o;
         default: ;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         rstate                <= R_IDLE;
         s_axi_control_arready <= 1'b0;
         s_axi_control_rvalid  <= 1'b0;
         s_axi_control_rdata   <= '0;
      end else begin
         unique case (rstate)
            R_IDLE: begin
               if (s_axi_control_arready && s_axi_control_arvalid) begin
                  rstate                <= R_DATA;
                  s_axi_control_rdata   <= rd_mux;
                  s_axi_control_rvalid  <= 1'b1;
                  s_axi_control_arready <= 1'b0;
               end else begin
                  s_axi_control_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi_control_rready) begin
                  rstate                <= R_IDLE;
                  s_axi_control_rvalid  <= 1'b0;
                  s_axi_control_arready <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmac_ctrl_slave.sv
// Self-checking bench for dmac_ctrl_slave: vector table, hand sequences
// for ordering/stall/start/reset cases, and a randomized model comparison.
module tb_dmac_ctrl_slave;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [11:0] awaddr = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [1:0]  bresp;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [11:0] araddr = '0;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        start_o;
   logic [31:0] src_addr_o;
   logic [31:0] dst_addr_o;
   logic [31:0] byte_len_o;
   logic        busy = 1'b0;
   logic        done = 1'b0;

   dmac_ctrl_slave dut (
      .ap_clk(ap_clk),
      .ap_rst(ap_rst),
      .s_axi_control_awvalid(awvalid),
      .s_axi_control_awready(awready),
      .s_axi_control_awaddr(awaddr),
      .s_axi_control_wvalid(wvalid),
      .s_axi_control_wready(wready),
      .s_axi_control_wdata(wdata),
      .s_axi_control_wstrb(wstrb),
      .s_axi_control_bvalid(bvalid),
      .s_axi_control_bready(bready),
      .s_axi_control_bresp(bresp),
      .s_axi_control_arvalid(arvalid),
      .s_axi_control_arready(arready),
      .s_axi_control_araddr(araddr),
      .s_axi_control_rvalid(rvalid),
      .s_axi_control_rready(rready),
      .s_axi_control_rdata(rdata),
      .s_axi_control_rresp(rresp),
      .start_o(start_o),
      .src_addr_o(src_addr_o),
      .dst_addr_o(dst_addr_o),
      .byte_len_o(byte_len_o),
      .busy_i(busy),
      .done_i(done)
   );

   always #5 ap_clk = ~ap_clk;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int exp_start = 0;

   // Counts cycles in which start_o is high; a clean pulse adds exactly 1.
   always @(negedge ap_clk) if (start_o) start_cnt++;

   // Reference model: registers by byte offset, done flag.
   logic [31:0] m_len, m_src, m_dst;
   bit          m_done;

   task automatic m_reset();
      m_len = 0; m_src = 0; m_dst = 0; m_done = 0;
   endtask

   function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   task automatic m_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      int off;
      off = int'(a) % 64 / 4 * 4;
      if (off == 'h14) m_len = m_merge(m_len, d, s);
      else if (off == 'h18) m_src = m_merge(m_src, d, s);
      else if (off == 'h1C) m_dst = m_merge(m_dst, d, s);
      else if (off == 'h10 && s[0] && d[0] && !busy) begin
         exp_start++;
         m_done = 0;
      end
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a);
      int off;
      off = int'(a) % 64 / 4 * 4;
      if (off == 'h14) return m_len;
      if (off == 'h18) return m_src;
      if (off == 'h1C) return m_dst;
      if (off == 'h10) return {30'd0, m_done, busy};
      return 32'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic aw_beat(input logic [11:0] a, input int dly);
      repeat (dly) @(negedge ap_clk);
      awaddr = a;
      awvalid = 1'b1;
      for (int i = 0; i < 50 && !awready; i++) @(negedge ap_clk);
      if (!awready) chk("aw_timeout", 32'(awready), 32'd1);
      @(negedge ap_clk);
      awvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input int dly);
      repeat (dly) @(negedge ap_clk);
      wdata = d;
      wstrb = s;
      wvalid = 1'b1;
      for (int i = 0; i < 50 && !wready; i++) @(negedge ap_clk);
      if (!wready) chk("w_timeout", 32'(wready), 32'd1);
      @(negedge ap_clk);
      wvalid = 1'b0;
   endtask

   task automatic wait_bvalid();
      for (int i = 0; i < 50 && !bvalid; i++) @(negedge ap_clk);
      if (!bvalid) chk("b_timeout", 32'(bvalid), 32'd1);
   endtask

   task automatic b_take(input int stall, output int held);
      held = 0;
      wait_bvalid();
      for (int k = 0; k < stall; k++) begin
         @(negedge ap_clk);
         if (bvalid) held++;
      end
      bready = 1'b1;
      @(negedge ap_clk);
      bready = 1'b0;
   endtask

   task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int stall);
      int held;
      fork
         aw_beat(a, awd);
         w_beat(d, s, wd);
      join
      b_take(stall, held);
      m_write(a, d, s);
   endtask

   task automatic do_read(input logic [11:0] a, output logic [31:0] d);
      araddr = a;
      arvalid = 1'b1;
      for (int i = 0; i < 50 && !arready; i++) @(negedge ap_clk);
      if (!arready) chk("ar_timeout", 32'(arready), 32'd1);
      @(negedge ap_clk);
      arvalid = 1'b0;
      chk("rd_latency", 32'(rvalid), 32'd1);
      d = rdata;
      rready = 1'b1;
      @(negedge ap_clk);
      rready = 1'b0;
   endtask

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [31:0] rd;
      int held;

      vecs[0]  = '{1, 12'h018, 32'h2000_0000, 4'hF, 32'h0};
      vecs[1]  = '{0, 12'h018, 32'h0,         4'h0, 32'h2000_0000};
      vecs[2]  = '{1, 12'h014, 32'h1111_1111, 4'hF, 32'h0};
      vecs[3]  = '{1, 12'h014, 32'hAABB_CCDD, 4'h3, 32'h0};
      vecs[4]  = '{0, 12'h014, 32'h0,         4'h0, 32'h1111_CCDD};
      vecs[5]  = '{1, 12'h040, 32'hDEAD_BEEF, 4'hF, 32'h0};
      vecs[6]  = '{0, 12'h040, 32'h0,         4'h0, 32'h0};
      vecs[7]  = '{0, 12'h018, 32'h0,         4'h0, 32'h2000_0000};
      vecs[8]  = '{1, 12'h01C, 32'h3000_0000, 4'hF, 32'h0};
      vecs[9]  = '{0, 12'h01C, 32'h0,         4'h0, 32'h3000_0000};
      vecs[10] = '{1, 12'h858, 32'h1234_5678, 4'hF, 32'h0};
      vecs[11] = '{0, 12'h018, 32'h0,         4'h0, 32'h1234_5678};

      m_reset();
      repeat (3) @(negedge ap_clk);
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_wready", 32'(wready), 32'd0);
      chk("rst_arready", 32'(arready), 32'd0);
      ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("rel_ready", {29'd0, awready, wready, arready}, 32'd7);
      chk("rel_valids", {30'd0, bvalid, rvalid}, 32'd0);
      chk("rel_rdata", rdata, 32'd0);
      chk("rel_start", 32'(start_o), 32'd0);
      chk("rel_regs", src_addr_o | dst_addr_o | byte_len_o, 32'd0);

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0);
            chk("vec_bresp", 32'(bresp), 32'd0);
            chk("vec_len", byte_len_o, m_len);
            chk("vec_src", src_addr_o, m_src);
            chk("vec_dst", dst_addr_o, m_dst);
         end else begin
            do_read(vecs[i].addr, rd);
            chk("vec_rd", rd, vecs[i].exp);
            chk("vec_rresp", 32'(rresp), 32'd0);
         end
      end

      fork
         aw_beat(12'h018, 0);
         w_beat(32'hABCD_0000, 4'hF, 2);
      join
      b_take(3, held);
      m_write(12'h018, 32'hABCD_0000, 4'hF);
      chk("bvalid_held", 32'(held), 32'd3);
      chk("stall_bresp", 32'(bresp), 32'd0);
      chk("b_drop", 32'(bvalid), 32'd0);
      chk("stall_src", src_addr_o, 32'hABCD_0000);

      do_write(12'h014, 32'd16384, 4'hF, 2, 0, 0);
      chk("w_first_len", byte_len_o, 32'd16384);
      do_write(12'h01C, 32'h3000_0001, 4'hF, 0, 0, 1);
      chk("same_cycle_dst", dst_addr_o, 32'h3000_0001);

      busy = 1'b0;
      done = 1'b1;
      @(negedge ap_clk);
      done = 1'b0;
      m_done = 1;
      do_write(12'h010, 32'h1, 4'hF, 0, 0, 0);
      repeat (2) @(negedge ap_clk);
      chk("start_pulse", 32'(start_cnt), 32'(exp_start));
      chk("start_one", 32'(exp_start), 32'd1);
      do_read(12'h010, rd);
      chk("start_clr_done", rd, 32'h0);
      busy = 1'b1;
      @(negedge ap_clk);
      do_read(12'h010, rd);
      chk("rd_busy", rd, 32'h1);
      do_write(12'h010, 32'h1, 4'hF, 0, 0, 0);
      repeat (2) @(negedge ap_clk);
      chk("busy_no_start", 32'(start_cnt), 32'd1);
      busy = 1'b0;
      done = 1'b1;
      @(negedge ap_clk);
      done = 1'b0;
      m_done = 1;
      do_read(12'h010, rd);
      chk("rd_done", rd, 32'h2);
      chk("rd_done_mask", rd & 32'hFFFF_FFF2, 32'h2);
      do_write(12'h010, 32'h1, 4'hE, 0, 0, 0);
      do_read(12'h010, rd);
      chk("strb0_off", rd, 32'h2);

      for (int n = 0; n < 60; n++) begin
         logic [11:0] a;
         a = 12'($urandom) & 12'hFFC;
         if ($urandom_range(1)) a = {6'($urandom), 6'h10 + 6'($urandom_range(3) * 4)};
         busy = 1'($urandom);
         if ($urandom_range(7) == 0) begin
            done = 1'b1;
            @(negedge ap_clk);
            done = 1'b0;
            m_done = 1;
         end
         if ($urandom_range(1)) begin
            do_write(a, $urandom, 4'($urandom), $urandom_range(2), $urandom_range(2),
                     $urandom_range(2));
         end else begin
            do_read(a, rd);
            chk("rand_rd", rd, m_read(a));
         end
      end
      repeat (2) @(negedge ap_clk);
      chk("rand_starts", 32'(start_cnt), 32'(exp_start));
      chk("rand_len", byte_len_o, m_len);
      chk("rand_src", src_addr_o, m_src);
      chk("rand_dst", dst_addr_o, m_dst);
      busy = 1'b0;

      fork
         aw_beat(12'h018, 0);
         w_beat(32'hCAFE_F00D, 4'hF, 0);
      join
      wait_bvalid();
      araddr = 12'h014;
      arvalid = 1'b1;
      for (int i = 0; i < 50 && !arready; i++) @(negedge ap_clk);
      @(negedge ap_clk);
      arvalid = 1'b0;
      chk("pend_both", {30'd0, bvalid, rvalid}, 32'd3);
      #1 ap_rst = 1'b1;
      #1;
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_regs", src_addr_o | dst_addr_o | byte_len_o, 32'd0);
      chk("rst_start", 32'(start_o), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      m_reset();
      @(negedge ap_clk);
      ap_rst = 1'b0;
      @(negedge ap_clk);
      do_write(12'h018, 32'h5555_AAAA, 4'hF, 0, 0, 0);
      chk("post_rst_src", src_addr_o, 32'h5555_AAAA);
      do_read(12'h018, rd);
      chk("post_rst_rd", rd, 32'h5555_AAAA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmac_ctrl_slave.md
Name: dmac_ctrl_slave

Overview:
AXI4-Lite control responder for the DMA controller. It terminates the host-side s_axi_control interface and holds the DMA configuration registers: source address, destination address and byte length. It issues a one-cycle start pulse to the DMA engine and reports busy/done status back to the host. It sits inside DMAC_TOP between the s_axi_control port pins and the read/write engines.

Parameters:
C_S_AXI_CONTROL_ADDR_WIDTH, 12, control address width in bits
C_S_AXI_CONTROL_DATA_WIDTH, 32, control data width in bits; only 32 is supported

Ports:
ap_clk  in  1  single clock
ap_rst  in  1  asynchronous, active-high reset
s_axi_control_awvalid  in  1  write-address valid
s_axi_control_awready  out  1  write-address ready
s_axi_control_awaddr  in  ADDR_WIDTH  write byte address
s_axi_control_wvalid  in  1  write-data valid
s_axi_control_wready  out  1  write-data ready
s_axi_control_wdata  in  32  write data
s_axi_control_wstrb  in  4  byte enables
s_axi_control_bvalid  out  1  write-response valid
s_axi_control_bready  in  1  write-response ready
s_axi_control_bresp  out  2  write response; always 2'b00 (OKAY)
s_axi_control_arvalid  in  1  read-address valid
s_axi_control_arready  out  1  read-address ready
s_axi_control_araddr  in  ADDR_WIDTH  read byte address
s_axi_control_rvalid  out  1  read-data valid
s_axi_control_rready  in  1  read-data ready
s_axi_control_rdata  out  32  read data
s_axi_control_rresp  out  2  read response; always 2'b00
start_o  out  1  one-cycle start pulse to the engine
src_addr_o  out  32  SRC register
dst_addr_o  out  32  DST register
byte_len_o  out  32  BYTE_LEN register
busy_i  in  1  engine transfer in progress (level)
done_i  in  1  engine completion (one-cycle pulse)

Behaviour:
- Reset values: all registers 0; awready, wready and arready = 0 while ap_rst is high, then 1 in the first cycle after release; bvalid, rvalid, start_o = 0; rdata = 0. Asserting reset mid-transaction aborts it with no response.
- Register map (decode awaddr[5:2] / araddr[5:2]; upper bits ignored):
  - 0x10 USER_CTRL: bit0 W = start; R = busy_i. bit1 R = done_sticky. Other bits read 0.
  - 0x14 BYTE_LEN, 0x18 SRC, 0x1C DST: read/write, 32 bits each.
- Unmapped offsets: reads return 0; writes are dropped; response is still OKAY.
- Write path, states W_IDLE and W_RESP:
  - In W_IDLE, awready = 1 until an AW beat is captured, and wready = 1 until a W beat is captured. AW and W are accepted in either order or in the same cycle; each is held in its own buffer.
  - On the cycle after both buffers are full: apply the register write with wstrb byte masking, go to W_RESP, set bvalid = 1.
  - In W_RESP, awready = wready = 0. bvalid holds until bready; on the handshake go to W_IDLE and clear both buffers.
- Write to USER_CTRL with wstrb[0] = 1 and wdata[0] = 1:
  - busy_i = 0: start_o = 1 for exactly one cycle (the register-update cycle) and done_sticky clears.
  - busy_i = 1: start is ignored; no pulse; done unchanged.
- done_i = 1 sets done_sticky. If a start clear occurs in the same cycle, start wins and done_sticky = 0.
- Read path, states R_IDLE and R_DATA:
  - In R_IDLE, arready = 1. On the AR handshake, register rdata from the current register state, set rvalid = 1 the next cycle, and go to R_DATA (arready = 0).
  - rdata and rvalid hold until rready; then return to R_IDLE. Read latency is 1 cycle from the AR handshake.
- Read and write paths are independent and may run in the same cycle. A read of a register being written in that cycle returns the old value.
- Config registers may be written while busy. The engine samples src/dst/len only on start_o.

Decomposition:
- Shared package dmac_pkg:
  - address localparams ADDR_USER_CTRL = 6'h10, ADDR_BYTE_LEN_DATA = 6'h14, ADDR_SRC_DATA = 6'h18, ADDR_DST_DATA = 6'h1C;
  - bit indices CTRL_START_BIT = 0, CTRL_DONE_BIT = 1;
  - RESP_OKAY = 2'b00;
  - typedef enum for the write and read FSM states.
- No sub-module; the single module covers both channel FSMs and the register file.

Test Plan:
- Sequential AW then W to 0x18, data 0x2000_0000 with wstrb 4'hF, bready low for 3 cycles -> bvalid held 3 cycles, bresp 0; src_addr_o = 0x2000_0000; read 0x18 returns 0x2000_0000 with rvalid one cycle after arready handshake.
- W beat presented 2 cycles before AW to 0x14, data 16384 -> write completes, byte_len_o = 16384; same-cycle AW+W to 0x1C, data 0x3000_0000 -> dst_addr_o = 0x3000_0000.
- Write 0x10 = 1 with busy_i = 0 -> start_o high exactly 1 cycle. Then busy_i = 1: read 0x10 = 0x1 and a second start write gives no pulse. Then done_i pulse with busy_i = 0 -> read 0x10 = 0x2, and (rdata & 0xFFFF_FFF2) == 2.
- Partial strobe: write 0x14 = 0xAABB_CCDD with wstrb 4'b0011 over prior 0x1111_1111 -> readback 0x1111_CCDD.
- Unmapped 0x40 write 0xDEAD_BEEF -> bresp OKAY, no register changes; read 0x40 -> 0.
- Assert ap_rst while bvalid and rvalid are pending -> both drop immediately; all registers 0, start_o = 0; after release, a new write/read to 0x18 completes normally.
